demux32_router: RTL and testbench

DEMUX32_ROUTER -- requirements
Module: demux32_router

---
 rtl/demux32_router_if.sv | 39 +++
 rtl/demux32_router.sv | 88 ++++++++
 tb/tb_demux32_router.sv | 198 +++++++++++++++++++
 3 files changed

// File: rtl/demux32_router_if.sv
// Bundle for the two-way demux router: one producer stream in,
// two consumer streams out, plus queue occupancies.
interface demux32_router_if #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 2
) ();
  localparam int CW = $clog2(DEPTH) + 1;

  logic [WIDTH-1:0] in_data;
  logic             in_sel;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] out0_data;
  logic             out0_valid;
  logic             out0_ready;
  logic [WIDTH-1:0] out1_data;
  logic             out1_valid;
  logic             out1_ready;
  logic [CW-1:0]    cnt0;
  logic [CW-1:0]    cnt1;

  modport slave (
    input  in_data, in_sel, in_valid,
    input  out0_ready, out1_ready,
    output in_ready,
    output out0_data, out0_valid,
    output out1_data, out1_valid,
    output cnt0, cnt1
  );

  modport master (
    output in_data, in_sel, in_valid,
    output out0_ready, out1_ready,
    input  in_ready,
    input  out0_data, out0_valid,
    input  out1_data, out1_valid,
    input  cnt0, cnt1
  );
endinterface

// File: rtl/demux32_router.sv
// Routes each accepted word into one of two independent FIFO queues;
// each queue drains to its own consumer with one cycle of latency.
module demux32_router #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 2
) (
  input  logic               clk,
  input  logic               rst_n,
  demux32_router_if.slave    bus
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [PW-1:0]    wp_q [2];
  logic [PW-1:0]    wp_d [2];
  logic [PW-1:0]    rp_q [2];
  logic [PW-1:0]    rp_d [2];
  logic [CW-1:0]    cnt_q [2];
  logic [CW-1:0]    cnt_d [2];
  logic [WIDTH-1:0] mem_q [2][DEPTH];
  logic [WIDTH-1:0] mem_d [2][DEPTH];

  logic [1:0] full;
  logic [1:0] valid;
  logic [1:0] rdy;
  logic [1:0] push;
  logic [1:0] pop;

  always_comb begin
    rdy = {bus.out1_ready, bus.out0_ready};
    for (int n = 0; n < 2; n++) begin
      full[n]  = (cnt_q[n] == CW'(DEPTH));
      valid[n] = (cnt_q[n] != '0);
      pop[n]   = valid[n] & rdy[n];
      push[n]  = bus.in_valid & ~full[n]
               & (bus.in_sel == 1'(n));
    end
  end

  // Full check only looks at the selected queue; no pass-through.
  assign bus.in_ready = ~full[bus.in_sel];

  always_comb begin
    wp_d  = wp_q;
    rp_d  = rp_q;
    cnt_d = cnt_q;
    mem_d = mem_q;
    for (int n = 0; n < 2; n++) begin
      if (push[n]) begin
        mem_d[n][wp_q[n]] = bus.in_data;
        wp_d[n] = wp_q[n] + PW'(1);
      end
      if (pop[n]) begin
        rp_d[n] = rp_q[n] + PW'(1);
      end
      unique case (1'b1)
        push[n] & ~pop[n]: cnt_d[n] = cnt_q[n] + CW'(1);
        pop[n] & ~push[n]: cnt_d[n] = cnt_q[n] - CW'(1);
        default:           cnt_d[n] = cnt_q[n];
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int n = 0; n < 2; n++) begin
        wp_q[n]  <= '0;
        rp_q[n]  <= '0;
        cnt_q[n] <= '0;
      end
    end else begin
      wp_q  <= wp_d;
      rp_q  <= rp_d;
      cnt_q <= cnt_d;
    end
  end

  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  assign bus.out0_valid = valid[0];
  assign bus.out1_valid = valid[1];
  assign bus.out0_data  = valid[0] ? mem_q[0][rp_q[0]] : '0;
  assign bus.out1_data  = valid[1] ? mem_q[1][rp_q[1]] : '0;
  assign bus.cnt0       = cnt_q[0];
  assign bus.cnt1       = cnt_q[1];
endmodule

// File: tb/tb_demux32_router.sv
// Bench for demux32_router: queue-based model checked every cycle,
// directed scenarios with literal expectations, then random traffic.
module tb_demux32_router;
  localparam int WIDTH = 32;
  localparam int DEPTH = 2;

  logic clk;
  logic rst_n;
  int   total;
  int   bad;

  logic [WIDTH-1:0] mq0 [$];
  logic [WIDTH-1:0] mq1 [$];
  logic [WIDTH-1:0] got0 [$];
  logic [WIDTH-1:0] got1 [$];

  demux32_router_if #(.WIDTH(WIDTH), .DEPTH(DEPTH)) bus ();

  demux32_router #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string name,
                     input logic [63:0] act,
                     input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Model: two plain queues, updated from the handshake rules.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mq0.delete();
      mq1.delete();
    end else begin
      bit acc, p0, p1;
      logic sel;
      logic [WIDTH-1:0] d;
      sel = bus.in_sel;
      d   = bus.in_data;
      acc = bus.in_valid &&
            ((sel ? mq1.size() : mq0.size()) < DEPTH);
      p0  = bus.out0_ready && mq0.size() > 0;
      p1  = bus.out1_ready && mq1.size() > 0;
      if (p0) void'(mq0.pop_front());
      if (p1) void'(mq1.pop_front());
      if (acc) begin
        if (sel) mq1.push_back(d);
        else     mq0.push_back(d);
      end
    end
  end

  always @(negedge clk) begin
    #2;
    chk("cnt0", 64'(bus.cnt0), 64'(mq0.size()));
    chk("cnt1", 64'(bus.cnt1), 64'(mq1.size()));
    chk("out0_valid", 64'(bus.out0_valid), 64'(mq0.size() > 0));
    chk("out1_valid", 64'(bus.out1_valid), 64'(mq1.size() > 0));
    chk("out0_data", 64'(bus.out0_data),
        mq0.size() > 0 ? 64'(mq0[0]) : 64'd0);
    chk("out1_data", 64'(bus.out1_data),
        mq1.size() > 0 ? 64'(mq1[0]) : 64'd0);
    chk("in_ready", 64'(bus.in_ready),
        64'(((bus.in_sel ? mq1.size() : mq0.size()) < DEPTH)));
  end

  // Drive at the falling edge, then settle so combinational
  // outputs can be inspected before the next rising edge.
  task automatic drive(input logic v, input logic s,
                       input logic [WIDTH-1:0] d,
                       input logic r0, input logic r1);
    @(negedge clk);
    rst_n          = 1'b1;
    bus.in_valid   = v;
    bus.in_sel     = s;
    bus.in_data    = d;
    bus.out0_ready = r0;
    bus.out1_ready = r1;
    #3;
  endtask

  initial begin
    total = 0;
    bad   = 0;
    rst_n          = 1'b0;
    bus.in_valid   = 1'b0;
    bus.in_sel     = 1'b0;
    bus.in_data    = '0;
    bus.out0_ready = 1'b0;
    bus.out1_ready = 1'b0;
    repeat (2) @(negedge clk);
    #3;
    chk("rst cnt0", 64'(bus.cnt0), 64'd0);
    chk("rst out0_valid", 64'(bus.out0_valid), 64'd0);
    chk("rst in_ready", 64'(bus.in_ready), 64'd1);

    // single push to queue 0
    drive(1, 0, 32'hA5A5A5A5, 0, 0);
    chk("a5 in_ready", 64'(bus.in_ready), 64'd1);
    chk("a5 no comb path", 64'(bus.out0_valid), 64'd0);
    drive(0, 0, 0, 0, 0);
    chk("a5 out0_valid", 64'(bus.out0_valid), 64'd1);
    chk("a5 out0_data", 64'(bus.out0_data), 64'hA5A5A5A5);
    chk("a5 cnt0", 64'(bus.cnt0), 64'd1);
    chk("a5 out1_valid", 64'(bus.out1_valid), 64'd0);
    chk("a5 out1_data", 64'(bus.out1_data), 64'd0);
    drive(0, 0, 0, 1, 0);
    drive(0, 0, 0, 1, 1);
    chk("drain cnt0", 64'(bus.cnt0), 64'd0);

    // fill queue 1, third offer refused, then drain in order
    drive(1, 1, 32'h1, 0, 0);
    drive(1, 1, 32'h2, 0, 0);
    drive(1, 1, 32'h3, 0, 0);
    chk("q1 full in_ready", 64'(bus.in_ready), 64'd0);
    chk("q1 full cnt1", 64'(bus.cnt1), 64'd2);
    drive(0, 1, 0, 0, 1);
    chk("q1 head 1", 64'(bus.out1_data), 64'h1);
    drive(0, 1, 0, 0, 1);
    chk("q1 head 2", 64'(bus.out1_data), 64'h2);
    drive(0, 0, 0, 0, 1);
    chk("q1 empty", 64'(bus.cnt1), 64'd0);

    // queue 0 full does not block queue 1
    drive(1, 0, 32'h10, 0, 0);
    drive(1, 0, 32'h11, 0, 0);
    drive(1, 1, 32'h77, 0, 0);
    chk("other q in_ready", 64'(bus.in_ready), 64'd1);
    drive(1, 0, 32'h99, 1, 0);
    chk("full no passthru", 64'(bus.in_ready), 64'd0);
    chk("77 cnt1", 64'(bus.cnt1), 64'd1);
    chk("77 cnt0", 64'(bus.cnt0), 64'd2);
    drive(1, 0, 32'h55, 1, 0);
    chk("pp before cnt0", 64'(bus.cnt0), 64'd1);
    chk("pp before head", 64'(bus.out0_data), 64'h11);
    drive(0, 0, 0, 0, 0);
    chk("pp cnt0", 64'(bus.cnt0), 64'd1);
    chk("pp head", 64'(bus.out0_data), 64'h55);
    repeat (3) drive(0, 0, 0, 1, 1);
    chk("drained", 64'({bus.cnt0, bus.cnt1}), 64'd0);

    // alternating stream, both consumers always ready
    got0.delete();
    got1.delete();
    for (int i = 0; i < 13; i++) begin
      drive(i < 10, 1'(i % 2), 32'h100 + 32'(i), 1, 1);
      if (bus.out0_valid) got0.push_back(bus.out0_data);
      if (bus.out1_valid) got1.push_back(bus.out1_data);
    end
    chk("stream n0", 64'(got0.size()), 64'd5);
    chk("stream n1", 64'(got1.size()), 64'd5);
    for (int i = 0; i < 5 && i < got0.size(); i++)
      chk("stream p0", 64'(got0[i]), 64'(32'h100 + 32'(2 * i)));
    for (int i = 0; i < 5 && i < got1.size(); i++)
      chk("stream p1", 64'(got1[i]), 64'(32'h101 + 32'(2 * i)));

    // async reset between edges with both queues full
    drive(1, 0, 32'hA, 0, 0);
    drive(1, 0, 32'hB, 0, 0);
    drive(1, 1, 32'hC, 0, 0);
    drive(1, 1, 32'hD, 0, 0);
    drive(1, 0, 32'hE, 0, 0);
    chk("pre-rst cnt0", 64'(bus.cnt0), 64'd2);
    chk("pre-rst cnt1", 64'(bus.cnt1), 64'd2);
    rst_n = 1'b0;
    #1;
    chk("arst cnt0", 64'(bus.cnt0), 64'd0);
    chk("arst cnt1", 64'(bus.cnt1), 64'd0);
    chk("arst valid", 64'({bus.out0_valid, bus.out1_valid}), 64'd0);
    chk("arst data0", 64'(bus.out0_data), 64'd0);
    chk("arst data1", 64'(bus.out1_data), 64'd0);
    chk("arst in_ready", 64'(bus.in_ready), 64'd1);
    drive(0, 0, 0, 0, 0);

    // random traffic with occasional mid-cycle reset
    for (int i = 0; i < 3000; i++) begin
      drive($urandom_range(0, 3) != 0, 1'($urandom_range(0, 1)),
            $urandom, 1'($urandom_range(0, 1)),
            1'($urandom_range(0, 1)));
      if ($urandom_range(0, 199) == 0) rst_n = 1'b0;
    end
    repeat (3) drive(0, 0, 0, 1, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
